fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose parameter CMD_WIDTH, default 16, instruction word width.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 8, program-counter and instruction-memory address width (256 words).
REQ-003 The block SHALL expose parameter FIFO_DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-004 The block SHALL expose parameter RESET_PC, default 0, PC value after reset.
REQ-005 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port run  input  1  enables issuing new fetches.
REQ-008 The block SHALL have ports prog_we  input  1, prog_addr  input  ADDR_WIDTH, prog_data  input  CMD_WIDTH: instruction-memory write.
REQ-009 The block SHALL have ports redirect_valid  input  1, redirect_pc  input  ADDR_WIDTH: jump request from decode/execute.
REQ-010 The block SHALL have ports instr_valid  output  1, instr_data  output  CMD_WIDTH, instr_pc  output  ADDR_WIDTH: instruction to decode.
REQ-011 The block SHALL have port instr_ready  input  1  decode accepts the instruction this cycle.
REQ-012 The block SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently queued.

Function
REQ-013 Instruction memory SHALL be 2**ADDR_WIDTH x CMD_WIDTH, synchronous write on prog_we, synchronous read (data registered one edge after address).
REQ-014 A simultaneous prog write and fetch read to the same address SHALL return the old word (read-before-write).
REQ-015 A fetch SHALL issue on an edge when run=1, redirect_valid=0 and (fifo_level + in-flight - pop_this_cycle) < FIFO_DEPTH; issue reads mem[pc], sets in-flight, pc <= pc+1.
REQ-016 PC SHALL wrap 2**ADDR_WIDTH-1 -> 0 without stall.
REQ-017 An in-flight read SHALL be pushed into the FIFO with its PC on the next edge; instr_valid rises after that edge (issue-to-valid latency 2 edges).
REQ-018 instr_valid SHALL equal (fifo_level != 0); instr_data/instr_pc SHALL show the FIFO head, and 0 when empty.
REQ-019 Pop SHALL occur on an edge with instr_valid=1 and instr_ready=1; push and pop on the same edge SHALL leave fifo_level unchanged.
REQ-020 With run=1 and instr_ready held 1, sustained throughput SHALL be one instruction per cycle with no bubbles.
REQ-021 Holding instr_valid=1, instr_data and instr_pc SHALL stay stable until popped (no overwrite, no drop).
REQ-022 redirect_valid=1 SHALL, on that edge, empty the FIFO, discard any in-flight read, ignore any pop, and load pc <= redirect_pc; this has priority over every other event.
REQ-023 After a redirect edge, the first instruction from redirect_pc SHALL be valid 2 edges later if run=1.
REQ-024 run=0 SHALL stop new issues only; in-flight data still lands and queued entries still drain.
REQ-025 The FIFO SHALL never exceed FIFO_DEPTH entries; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 Reset SHALL set pc=RESET_PC, FIFO empty, in-flight cleared, instr_valid=0, instr_data=0, instr_pc=0, fifo_level=0, immediately and independent of clk.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight instructions; instruction memory contents SHALL NOT be reset.

Verification
REQ-028 Load mem[0..3]=16'h1123,16'h2456,16'h3700,16'h5A0F, release reset, run=1, ready=1 -> instr_valid first high after 2nd edge with pc 0, then pcs 1,2,3 back-to-back, data matches.
REQ-029 ready=0 with run=1 -> fifo_level saturates at 4, instr_data/instr_pc hold pc 0 word; ready=1 -> pcs 0..3 then 4 with no gap or duplicate.
REQ-030 redirect_valid=1, redirect_pc=8'h40 while FIFO holds 3 entries -> fifo_level=0 next edge, next valid instr_pc=8'h40 two edges after redirect, no stale PC ever output.
REQ-031 Redirect to 8'hFE, ready=1 -> output pcs FE, FF, 00, 01.
REQ-032 prog_we to address currently being fetched with new value 16'hBEEF -> old word delivered; refetch after redirect to same address delivers 16'hBEEF.
REQ-033 Assert reset asynchronously with FIFO full and read in flight -> instr_valid=0 and fifo_level=0 before next clk edge; after release fetch resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode bundle: program-load port, redirect request, instruction
// output handshake and queue occupancy.
interface fetch_unit_if #(
    parameter int CMD_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          run;
    logic                          prog_we;
    logic [ADDR_WIDTH-1:0]         prog_addr;
    logic [CMD_WIDTH-1:0]          prog_data;
    logic                          redirect_valid;
    logic [ADDR_WIDTH-1:0]         redirect_pc;
    logic                          instr_valid;
    logic [CMD_WIDTH-1:0]          instr_data;
    logic [ADDR_WIDTH-1:0]         instr_pc;
    logic                          instr_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output run, prog_we, prog_addr, prog_data, redirect_valid, redirect_pc, instr_ready,
        input  instr_valid, instr_data, instr_pc, fifo_level
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_data, redirect_valid, redirect_pc, instr_ready,
        output instr_valid, instr_data, instr_pc, fifo_level
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: synchronous instruction RAM, one-deep read pipeline and a
// prefetch queue that feeds decode one word per cycle; redirects flush everything.
module fetch_unit #(
    parameter int CMD_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

    logic [CMD_WIDTH-1:0]  imem_r [MEM_DEPTH];
    logic [CMD_WIDTH-1:0]  rd_data_r;

    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] inflight_pc_r;

    logic [CMD_WIDTH-1:0]  q_data_r [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_r   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [LVL_W-1:0]      count_r;

    logic                  instr_valid_r;
    logic [CMD_WIDTH-1:0]  instr_data_r;
    logic [ADDR_WIDTH-1:0] instr_pc_r;

    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [LVL_W:0]        occupancy_s;
    logic [LVL_W-1:0]      remain_s;
    logic [LVL_W-1:0]      count_n_s;
    logic [PTR_W-1:0]      rd_ptr_n_s;
    logic [PTR_W-1:0]      wr_ptr_n_s;
    logic [CMD_WIDTH-1:0]  head_data_n_s;
    logic [ADDR_WIDTH-1:0] head_pc_n_s;

    // Handshake decode: a redirect cancels both the pop and the landing read.
    always_comb begin
        pop_s       = instr_valid_r & bus.instr_ready & ~bus.redirect_valid;
        push_s      = inflight_r & ~bus.redirect_valid;
        // Slots already promised (queued + in flight) less the one leaving now.
        occupancy_s = {1'b0, count_r} + (LVL_W+1)'(inflight_r) - (LVL_W+1)'(pop_s);
        issue_s     = bus.run & ~bus.redirect_valid &
                      (occupancy_s < (LVL_W+1)'(FIFO_DEPTH));
        remain_s    = count_r - LVL_W'(pop_s);
    end

    // Next queue pointers and occupancy.
    always_comb begin
        count_n_s  = count_r;
        rd_ptr_n_s = rd_ptr_r;
        wr_ptr_n_s = wr_ptr_r;
        if (bus.redirect_valid) begin
            count_n_s  = '0;
            rd_ptr_n_s = '0;
            wr_ptr_n_s = '0;
        end else begin
            count_n_s  = count_r + LVL_W'(push_s) - LVL_W'(pop_s);
            rd_ptr_n_s = rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_n_s = wr_ptr_r + PTR_W'(push_s);
        end
    end

    // Head of the queue after this edge, so the output port can be a register.
    always_comb begin
        head_data_n_s = '0;
        head_pc_n_s   = '0;
        if (count_n_s == LVL_W'(0)) begin
            head_data_n_s = '0;
            head_pc_n_s   = '0;
        end else if (remain_s == LVL_W'(0)) begin
            // Queue drains to nothing this edge, so the landing read becomes the head.
            head_data_n_s = rd_data_r;
            head_pc_n_s   = inflight_pc_r;
        end else begin
            head_data_n_s = q_data_r[rd_ptr_n_s];
            head_pc_n_s   = q_pc_r[rd_ptr_n_s];
        end
    end

    // Instruction RAM: write port plus registered read-before-write fetch port.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            imem_r[bus.prog_addr] <= bus.prog_data;
        end
        if (issue_s) begin
            rd_data_r <= imem_r[pc_r];
        end
    end

    // Queue storage; validity is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_data_r[wr_ptr_r] <= rd_data_r;
            q_pc_r[wr_ptr_r]   <= inflight_pc_r;
        end
    end

    // PC, in-flight tracking, queue control and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= ADDR_WIDTH'(RESET_PC);
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            instr_valid_r <= 1'b0;
            instr_data_r  <= '0;
            instr_pc_r    <= '0;
        end else begin
            if (bus.redirect_valid) begin
                pc_r <= bus.redirect_pc;
            end else if (issue_s) begin
                pc_r <= pc_r + ADDR_WIDTH'(1);
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
            rd_ptr_r      <= rd_ptr_n_s;
            wr_ptr_r      <= wr_ptr_n_s;
            count_r       <= count_n_s;
            instr_valid_r <= (count_n_s != LVL_W'(0));
            instr_data_r  <= head_data_n_s;
            instr_pc_r    <= head_pc_n_s;
        end
    end

    assign bus.instr_valid = instr_valid_r;
    assign bus.instr_data  = instr_data_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.fifo_level  = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency, back-pressure, redirect, wrap,
// read-before-write, async reset and run=0 drain.
module tb_fetch_unit;
    localparam int CW = 16;
    localparam int AW = 8;
    localparam int FD = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_mem [256];

    fetch_unit_if #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) bus ();

    fetch_unit #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .RESET_PC(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] pc);
        check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check_eq({tag, "_pc"},    32'(bus.instr_pc),    32'(pc));
        check_eq({tag, "_data"},  32'(bus.instr_data),  32'(exp_mem[pc]));
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check_eq({tag, "_level"}, 32'(bus.fifo_level),  32'd0);
        check_eq({tag, "_pc"},    32'(bus.instr_pc),    32'd0);
        check_eq({tag, "_data"},  32'(bus.instr_data),  32'd0);
    endtask

    task automatic restart();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.run            = 1'b0;
        bus.prog_we        = 1'b0;
        bus.prog_addr      = 8'h00;
        bus.prog_data      = 16'h0000;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.instr_ready    = 1'b0;

        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = {~8'(i), 8'(i)};
        end
        exp_mem[0] = 16'h1123;
        exp_mem[1] = 16'h2456;
        exp_mem[2] = 16'h3700;
        exp_mem[3] = 16'h5A0F;

        tick(1);
        for (int i = 0; i < 256; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 8'(i);
            bus.prog_data = exp_mem[i];
            tick(1);
        end
        bus.prog_we = 1'b0;
        check_empty("reset");

        // Basic streaming from reset
        reset           = 1'b0;
        bus.run         = 1'b1;
        bus.instr_ready = 1'b1;
        tick(1);
        check_eq("t1_lat1_valid", 32'(bus.instr_valid), 32'd0);
        tick(1);
        check_head("t1_pc0", 8'h00);
        check_eq("t1_word0", 32'(bus.instr_data), 32'h1123);
        for (int k = 1; k < 4; k++) begin
            tick(1);
            check_head("t1_stream", 8'(k));
        end
        check_eq("t1_word3", 32'(bus.instr_data), 32'h5A0F);

        // Back-pressure saturation and drain
        bus.instr_ready = 1'b0;
        restart();
        tick(2);
        check_head("t2_first", 8'h00);
        tick(6);
        check_eq("t2_level", 32'(bus.fifo_level), 32'd4);
        check_head("t2_hold", 8'h00);
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check_head("t2_drain", 8'(k));
        end

        // Redirect with three queued entries and a read in flight
        bus.instr_ready = 1'b0;
        restart();
        tick(4);
        check_eq("t3_level3", 32'(bus.fifo_level), 32'd3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h40;
        tick(1);
        check_empty("t3_flush");
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        tick(1);
        check_eq("t3_no_stale", 32'(bus.instr_valid), 32'd0);
        tick(1);
        check_head("t3_target", 8'h40);

        // PC wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hFE;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(2);
        check_head("t4_fe", 8'hFE);
        tick(1);
        check_head("t4_ff", 8'hFF);
        tick(1);
        check_head("t4_00", 8'h00);
        tick(1);
        check_head("t4_01", 8'h01);

        // Write colliding with the fetch read returns the old word
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h80;
        tick(1);
        bus.redirect_valid = 1'b0;
        bus.prog_we        = 1'b1;
        bus.prog_addr      = 8'h80;
        bus.prog_data      = 16'hBEEF;
        tick(1);
        bus.prog_we = 1'b0;
        tick(1);
        check_head("t5_old", 8'h80);
        check_eq("t5_old_word", 32'(bus.instr_data), 32'h7F80);
        exp_mem[8'h80] = 16'hBEEF;
        bus.redirect_valid = 1'b1;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(2);
        check_head("t5_new", 8'h80);

        // Asynchronous reset mid-operation
        bus.instr_ready = 1'b0;
        restart();
        tick(4);
        check_eq("t6_level3", 32'(bus.fifo_level), 32'd3);
        #3;
        reset = 1'b1;
        #1;
        check_empty("t6_async");
        #1;
        reset           = 1'b0;
        bus.instr_ready = 1'b1;
        tick(2);
        check_head("t6_resume0", 8'h00);
        tick(1);
        check_head("t6_resume1", 8'h01);

        // run=0: in-flight read lands, queue drains, nothing new issues
        bus.run         = 1'b0;
        bus.instr_ready = 1'b0;
        tick(3);
        check_eq("t7_level", 32'(bus.fifo_level), 32'd2);
        check_head("t7_hold", 8'h01);
        bus.instr_ready = 1'b1;
        tick(1);
        check_head("t7_pc2", 8'h02);
        tick(1);
        check_empty("t7_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
